// File: rtl/uart_rx_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the uart_rx_deser receiver.
//               - state_e     : receiver FSM states
//               - BIT_CNT_W   : width of the bit_count_o status output
//               - half_bit_cmp: counter value at which the mid-bit sample
//                               of the start bit is taken
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // The counter is cleared on the cycle after the falling edge is seen, so
    // the half-bit point relative to that edge is reached one count earlier.
    function automatic int half_bit_cmp(input int clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deser_if
// Description : Valid/ready word interface between the UART receiver and the
//               downstream byte consumer.
//   data_o  : received word, stable while valid_o is high
//   valid_o : holding register contains a word
//   ready_i : consumer accepts the word when valid_o & ready_i
//   master  : receiver side, slave : consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_deser_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_deser_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period counter for the UART receiver. Counts
//               0..CLKS_PER_BIT-1 while run_i is high, wraps, and is forced
//               to zero by clr_i or when not running.
//   clk, reset  : system clock, synchronous active-high reset
//   clr_i       : restart the count on the next cycle
//   run_i       : counter enabled
//   half_tick_o : count at the start-bit mid-point
//   full_tick_o : count at the last cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr_i,
    input  wire logic run_i,
    output logic      half_tick_o,
    output logic      full_tick_o
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_CMP = CNT_W'(half_bit_cmp(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0]  FULL_CMP = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == FULL_CMP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_tick_o = run_i && (cnt_q == HALF_CMP);
    assign full_tick_o = run_i && (cnt_q == FULL_CMP);

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deser
// Description : Oversampling UART receive deserializer. Synchronizes rx_i,
//               detects the start edge, samples each bit at mid-bit, checks
//               the stop bit and presents words through a one-entry
//               valid/ready holding register.
// Build macro : UART_RX_PARITY_EN - adds a parity bit between the last data
//               bit and the stop bit; otherwise parity_err_o is tied low.
// Ports       :
//   clk, reset   : system clock, synchronous active-high reset
//   rx_i         : asynchronous serial line, idles high
//   rx_if        : word output (data_o / valid_o / ready_i), master side
//   busy_o       : receiver not idle
//   bit_count_o  : data bits captured in the current frame
//   frame_err_o  : 1-cycle pulse, stop bit sampled low
//   overrun_o    : 1-cycle pulse, completed word dropped (register full)
//   parity_err_o : 1-cycle pulse, parity mismatch (word dropped)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              rx_i,
    uart_rx_deser_if.master        rx_if,
    output logic                   busy_o,
    output logic [BIT_CNT_W-1:0]   bit_count_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   parity_err_o
);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic                   frame_err;
    logic                   overrun;
    logic                   half_tick;
    logic                   full_tick;
    logic                   timer_clr;
    logic                   timer_run;

`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);
    logic par_q, par_d;
    logic parity_err;
`else
    // Parity sense has no effect when the parity bit is not compiled in.
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    // Counter restarts on every state change so each state measures its own
    // bit period from entry.
    assign timer_clr = (state_d != state_q);
    assign timer_run = (state_q != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (timer_clr),
        .run_i       (timer_run),
        .half_tick_o (half_tick),
        .full_tick_o (full_tick)
    );

    always_comb begin
        rx_meta_d = rx_i;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        bit_cnt_d = bit_cnt_q;
        frame_err = 1'b0;
        overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        parity_err = 1'b0;
`endif

        // Consumer side: an accept empties the register unless a commit
        // below refills it in the same cycle.
        if (valid_q && rx_if.ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Falling edge only, so a line stuck low never starts frames.
                if (!rx_s_q && rx_prev_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_tick) begin
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leave on the sample cycle so a start edge during the rest
                // of the stop bit is still caught.
                if (full_tick) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^{shift_q, par_q}) != PARITY_SENSE) begin
                        parity_err = 1'b1;
`endif
                    end else if (valid_q && !rx_if.ready_i) begin
                        overrun = 1'b1;
                    end else begin
                        hold_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            shift_q   <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign rx_if.data_o  = hold_q;
    assign rx_if.valid_o = valid_q;
    assign busy_o        = (state_q != IDLE);
    assign bit_count_o   = bit_cnt_q;
    assign frame_err_o   = frame_err;
    assign overrun_o     = overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = parity_err;
`else
    assign parity_err_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Parametrised UART receive deserializer.
- Replaces the per-edge baud sampling flop with a single-clock-domain oversampling receiver.
- Detects the start bit, samples each bit at mid-bit, checks the stop bit, and presents each received word through a one-entry valid/ready holding register.
- Sits between the external rx pin and the downstream byte consumer.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit period. Legal range >= 4, even values only.
- DATA_BITS, 8: data bits per frame, LSB first. Legal range 5..9.
- PARITY_ODD, 0: parity sense, 1 = odd, 0 = even. Used only when the parity feature is compiled in.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- rx_i  in  1  raw serial line, asynchronous, idles high
- data_o  out  DATA_BITS  received word, held while valid_o
- valid_o  out  1  word available in holding register
- ready_i  in  1  consumer accepts word when valid_o & ready_i
- busy_o  out  1  high whenever state != IDLE
- bit_count_o  out  4  data bits captured in current frame
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: completed word dropped
- parity_err_o  out  1  one-cycle pulse: parity mismatch

Behaviour:
- Reset values: data_o = 0, valid_o = 0, bit_count_o = 0, all pulse outputs = 0, state = IDLE, both synchronizer flops = 1.
- Reset mid-frame abandons the frame. Reset also discards an unaccepted word.
- rx_i passes through a 2-flop synchronizer (rx_s). T0 is the first cycle in IDLE in which rx_s = 0 and the previous rx_s = 1 (falling edge). A line held low never triggers a frame.
- Bit-period counter counts 0..CLKS_PER_BIT-1. It is cleared on each state entry and runs only outside IDLE.
- States:
  - IDLE -> START at T0.
  - START: sample at T0 + CLKS_PER_BIT/2. If rx_s = 0 -> DATA. If rx_s = 1 -> IDLE (glitch rejected, no outputs change).
  - DATA: data bit k (k = 0..DATA_BITS-1) sampled at T0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT. Each sample is shifted in LSB first and bit_count_o is incremented. After the last bit -> STOP, or -> PARITY when the feature is enabled.
  - STOP: sample one bit period later. Always -> IDLE on the sample cycle, so the next start edge can be seen during the remainder of the stop bit.
- Stop sampled 1:
  - Word is committed to the holding register.
  - valid_o rises the next cycle.
  - With 16/8, stop is sampled at T0+152 and valid_o rises at T0+153.
- Stop sampled 0: frame_err_o pulses for 1 cycle, the word is discarded, and the holding register is unchanged.
- bit_count_o returns to 0 on entering IDLE.
- Handshake:
  - valid_o stays high and data_o stays stable until a cycle with valid_o & ready_i.
  - valid_o falls the next cycle unless a new word commits in that same cycle.
  - ready_i is ignored while valid_o = 0.
- Commit while valid_o = 1 and ready_i = 0: overrun_o pulses, the new word is dropped, and the old word is retained.
- Commit in the same cycle as an accept: the new word loads, valid_o stays 1, and there is no overrun.
- frame_err takes priority over overrun; both never pulse for one frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA, sampled one bit period after the last data bit. STOP follows one period later, so valid_o shifts one bit period later (T0+169 for 16/8).
  - Mismatch against PARITY_ODD causes parity_err_o to pulse on the stop-sample cycle; the word is dropped.
  - frame_err has priority over parity_err.
- Undefined: no PARITY state, parity_err_o tied 0, PARITY_ODD ignored.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - width constant for bit_count_o (4)
  - function computing the half-bit compare value
- One sub-module, uart_bit_timer: bit-period counter with clear input and half/full tick outputs.
- Synchronizer, FSM, shift register and holding register stay in uart_rx_deser.

Test Plan:
- Defaults, ready_i = 1, send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> valid_o rises at T0+153 for 1 cycle, data_o = 0xA5, no error pulses.
- 2-cycle low glitch on rx_i in idle -> START entered then IDLE at T0+8. busy_o high for 8 cycles, no valid_o, no errors.
- Frame 0x3C with stop bit 0, line then held low 200 cycles -> frame_err_o pulse at T0+152, no valid_o, no retrigger until rx_i returns high.
- ready_i = 0, send 0x11 then 0x22 back-to-back -> data_o = 0x11 retained, overrun_o pulse on second stop sample. Raise ready_i -> 0x11 accepted, valid_o falls.
- ready_i asserted exactly on commit cycle of second word -> 0x11 accepted, data_o = 0x22 next cycle, valid_o continuous, no overrun.
- reset asserted at mid-data of a frame -> next cycle all outputs at reset values, state IDLE. Subsequent frame 0x5A received correctly. With UART_RX_PARITY_EN, PARITY_ODD = 0, send 0x07 with parity bit 0 -> parity_err_o pulse, no valid_o.
